// File: rtl/nipcb_recording_fifo.sv
`default_nettype none
// ============================================================================
// Module   : nipcb_recording_fifo
// Purpose  : First-word-fall-through FIFO for packed 4-channel recording
//            words (4 x 8-bit samples per word). Sits between the recording
//            write strobe and the register/bus read path. When the FIFO is
//            full, a write is dropped. Each drop sets a sticky overflow flag
//            and bumps a saturating 16-bit drop counter.
// Ports    : clk            system clock, posedge
//            rstn           asynchronous active-low reset
//            i_clear        synchronous flush, highest priority after reset
//            i_wr_en        one-cycle write strobe
//            i_wr_data      word to store
//            i_rd_ready     consumer accepts o_rd_data this cycle
//            o_rd_valid     head entry available
//            o_rd_data      head entry, 0 when empty
//            o_level        stored entries 0..DEPTH
//            o_full         level == DEPTH
//            o_empty        level == 0
//            o_almost_full  level >= AF_LEVEL
//            o_overflow     sticky: a write was dropped since last clear
//            o_drop_count   dropped writes, saturating at 16'hFFFF
// Revision : 1.0 - initial release
// ============================================================================
module nipcb_recording_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_clear,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_rd_ready,
  output logic                       o_rd_valid,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_overflow,
  output logic [15:0]                o_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] c_DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] c_AF_L    = LW'(AF_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_overflow;
  logic [15:0]       r_drop_cnt;

  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [LW-1:0]     w_level_nxt;

  // A full FIFO that is popped in the same cycle still has room for the write.
  assign w_pop  = ~r_empty & i_rd_ready;
  assign w_push = i_wr_en & (~r_full | w_pop);
  assign w_drop = i_wr_en & r_full & ~w_pop;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // Flags are registered from the next level so they always agree with o_level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_af       <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_af       <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == c_DEPTH_L);
      r_empty <= (w_level_nxt == '0);
      r_af    <= (w_level_nxt >= c_AF_L);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  // Storage is deliberately left unreset; contents are only visible once
  // the pointers/level say an entry is valid.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_valid    = ~r_empty;
  assign o_rd_data     = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level       = r_level;
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_almost_full = r_af;
  assign o_overflow    = r_overflow;
  assign o_drop_count  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nipcb_recording_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_nipcb_recording_fifo
// Purpose  : Self-checking bench for nipcb_recording_fifo. A queue-based
//            reference model tracks contents, overflow and drop count; all
//            outputs are compared against it after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nipcb_recording_fifo;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 12;

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_clear;
  logic              i_wr_en;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_rd_ready;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic [4:0]        o_level;
  logic              o_full;
  logic              o_empty;
  logic              o_almost_full;
  logic              o_overflow;
  logic [15:0]       o_drop_count;

  nipcb_recording_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF_LEVEL)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_clear      (i_clear),
    .i_wr_en      (i_wr_en),
    .i_wr_data    (i_wr_data),
    .i_rd_ready   (i_rd_ready),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .o_level      (o_level),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_almost_full(o_almost_full),
    .o_overflow   (o_overflow),
    .o_drop_count (o_drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_ovf;
  int          m_drops;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = m_q.size();
    check_eq("rd_valid", 32'(o_rd_valid), 32'(n > 0));
    check_eq("rd_data", o_rd_data, (n > 0) ? m_q[0] : 32'h0);
    check_eq("level", 32'(o_level), 32'(n));
    check_eq("full", 32'(o_full), 32'(n == DEPTH));
    check_eq("empty", 32'(o_empty), 32'(n == 0));
    check_eq("almost_full", 32'(o_almost_full), 32'(n >= AF_LEVEL));
    check_eq("overflow", 32'(o_overflow), 32'(m_ovf));
    check_eq("drop_count", 32'(o_drop_count), 32'(m_drops));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  // One clock: drive at negedge, advance model on the edge, compare #1 after.
  task automatic cycle(input bit wr, input logic [31:0] data, input bit rdy,
                       input bit clr, input bit chk);
    bit pop;
    bit room;
    @(negedge clk);
    i_wr_en    = wr;
    i_wr_data  = data;
    i_rd_ready = rdy;
    i_clear    = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else begin
      pop  = rdy && (m_q.size() > 0);
      room = (m_q.size() < DEPTH) || pop;
      if (pop) void'(m_q.pop_front());
      if (wr && room) m_q.push_back(data);
      if (wr && !room) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
    if (chk) check_all();
  endtask

  initial begin
    rstn = 1'b0; i_clear = 1'b0; i_wr_en = 1'b0; i_wr_data = '0; i_rd_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk) rstn = 1'b1;

    // Single write, read latency 1
    cycle(1, 32'hA1B2C3D4, 0, 0, 1);
    check_eq("t1_data", o_rd_data, 32'hA1B2C3D4);
    cycle(0, 0, 1, 0, 1);

    // Fill to full, drop one, drain in order
    for (int i = 0; i < 16; i++) cycle(1, 32'(i), 0, 0, 1);
    cycle(1, 32'hDEAD, 0, 0, 1);
    check_eq("t2_drops", 32'(o_drop_count), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check_eq("t2_order", o_rd_data, 32'(i));
      cycle(0, 0, 1, 0, 1);
    end

    // Full with simultaneous write and read
    for (int i = 0; i < 16; i++) cycle(1, 32'h100 + 32'(i), 0, 0, 1);
    cycle(1, 32'hBEEF, 1, 0, 1);
    check_eq("t3_level", 32'(o_level), 32'd16);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 1);

    // Streaming push/pop for 40 cycles
    for (int i = 0; i < 40; i++) cycle(1, 32'h2000 + 32'(i), 1, 0, 1);
    cycle(0, 0, 1, 0, 1);

    // Level 5 with overflow, then clear alongside a write
    for (int i = 0; i < 17; i++) cycle(1, 32'h300 + 32'(i), 0, 0, 1);
    for (int i = 0; i < 11; i++) cycle(0, 0, 1, 0, 1);
    check_eq("t5_level", 32'(o_level), 32'd5);
    cycle(1, 32'h5555, 1, 1, 1);
    check_eq("t5_clr_level", 32'(o_level), 32'd0);

    // Saturating drop counter
    for (int i = 0; i < 16; i++) cycle(1, 32'h400 + 32'(i), 0, 0, 1);
    for (int i = 0; i < 70000; i++)
      cycle(1, 32'($urandom), 0, 0, ((i % 8192) == 0) || (i >= 69990));
    check_eq("t6_sat", 32'(o_drop_count), 32'hFFFF);
    cycle(1, 32'h1, 1, 0, 1);
    check_eq("t6_hold", 32'(o_drop_count), 32'hFFFF);

    // Randomised traffic
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 3) != 0, 32'($urandom), ($urandom % 2) == 1,
            ($urandom % 200) == 0, 1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) cycle(1, 32'h600 + 32'(i), 0, 0, 1);
    @(posedge clk);
    #2 rstn = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rstn = 1'b1;
    i_wr_en = 1'b0;
    cycle(0, 0, 0, 0, 1);
    cycle(1, 32'h77, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
